// File: rtl/run_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : run_reset_sequencer
// Brief    : Staggered multi-channel reset release, run gating, cycle counting,
//            halt detection and watchdog timeout for the UP core.
// Revision : 1.0 - initial release
// ============================================================================
module run_reset_sequencer #(
    parameter int RST_CYCLES = 2,
    parameter int NUM_CH     = 2,
    parameter int STAGGER    = 1,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              halt_in,
    output logic [NUM_CH-1:0] ch_rst,
    output logic              run,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              done,
    output logic              timeout,
    output logic [2:0]        state_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RESET   = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_HALTED  = 3'd3;
    localparam logic [2:0] S_TIMEOUT = 3'd4;

    // Edge count (after the start edge) at which the last channel releases.
    localparam int               C_LAST   = RST_CYCLES + (NUM_CH - 1) * STAGGER;
    localparam int               C_HOLD_W = (C_LAST < 2) ? 1 : $clog2(C_LAST + 1);
    localparam logic [C_HOLD_W-1:0] C_LAST_V = C_HOLD_W'(C_LAST);
    localparam logic [CNT_W-1:0] C_TMO    = CNT_W'(TIMEOUT);
    localparam bit               C_WD_EN  = (TIMEOUT != 0);

    logic [2:0]          r_state;
    logic [C_HOLD_W-1:0] r_hold;
    logic [NUM_CH-1:0]   r_ch_rst;
    logic                r_run;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_done;
    logic                r_tmo;

    logic [2:0]          w_state_nxt;
    logic [C_HOLD_W-1:0] w_hold_inc;
    logic [C_HOLD_W-1:0] w_hold_nxt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [NUM_CH-1:0]   w_ch_fall;
    logic [NUM_CH-1:0]   w_ch_rst_nxt;
    logic                w_run_nxt;
    logic                w_done_nxt;
    logic                w_tmo_nxt;

    assign w_hold_inc = r_hold + C_HOLD_W'(1);
    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign w_ch_fall[i] = (w_hold_inc >= C_HOLD_W'(RST_CYCLES + i * STAGGER));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_hold   <= '0;
            r_ch_rst <= '1;
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hold   <= w_hold_nxt;
            r_ch_rst <= w_ch_rst_nxt;
            r_run    <= w_run_nxt;
            r_cnt    <= w_cnt_nxt;
            r_done   <= w_done_nxt;
            r_tmo    <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_RESET;
            end
            S_RESET: begin
                if (abort)                     w_state_nxt = S_IDLE;
                else if (w_hold_inc == C_LAST_V) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (abort)        w_state_nxt = S_IDLE;
                else if (halt_in) w_state_nxt = S_HALTED;
                else if (C_WD_EN && (w_cnt_inc == C_TMO)) w_state_nxt = S_TIMEOUT;
            end
            S_HALTED, S_TIMEOUT: begin
                if (start) w_state_nxt = S_RESET;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs follow the destination state; the counter only advances on RUN edges.
    always_comb begin
        w_ch_rst_nxt = '1;
        w_run_nxt    = 1'b0;
        w_done_nxt   = 1'b0;
        w_tmo_nxt    = 1'b0;
        w_hold_nxt   = '0;
        w_cnt_nxt    = r_cnt;
        case (w_state_nxt)
            S_IDLE: begin
                w_cnt_nxt = '0;
            end
            S_RESET: begin
                w_cnt_nxt = '0;
                if (r_state == S_RESET) begin
                    w_hold_nxt   = w_hold_inc;
                    w_ch_rst_nxt = ~w_ch_fall;
                end
            end
            S_RUN: begin
                w_ch_rst_nxt = '0;
                w_run_nxt    = 1'b1;
                if (r_state == S_RUN) w_cnt_nxt = w_cnt_inc;
            end
            S_HALTED: begin
                w_ch_rst_nxt = '0;
                w_done_nxt   = 1'b1;
            end
            S_TIMEOUT: begin
                w_tmo_nxt = 1'b1;
                if (r_state == S_RUN) w_cnt_nxt = w_cnt_inc;
            end
            default: w_cnt_nxt = '0;
        endcase
    end

    assign ch_rst      = r_ch_rst;
    assign run         = r_run;
    assign cycle_count = r_cnt;
    assign done        = r_done;
    assign timeout     = r_tmo;
    assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_run_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_reset_sequencer
// Brief    : Four parameterisations share one stimulus stream and are checked
//            against a per-configuration behavioural model every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, start = 1'b0, abort = 1'b0, halt_in = 1'b0;

    logic [1:0] a_ch, b_ch, d_ch;
    logic [3:0] c_ch;
    logic       a_run, b_run, c_run, d_run;
    logic       a_done, b_done, c_done, d_done;
    logic       a_tmo, b_tmo, c_tmo, d_tmo;
    logic [31:0] a_cnt, b_cnt, c_cnt;
    logic [4:0]  d_cnt;
    logic [2:0]  a_st, b_st, c_st, d_st;

    run_reset_sequencer u_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .halt_in(halt_in),
        .ch_rst(a_ch), .run(a_run), .cycle_count(a_cnt), .done(a_done),
        .timeout(a_tmo), .state_o(a_st));

    run_reset_sequencer #(.TIMEOUT(20)) u_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .halt_in(halt_in),
        .ch_rst(b_ch), .run(b_run), .cycle_count(b_cnt), .done(b_done),
        .timeout(b_tmo), .state_o(b_st));

    run_reset_sequencer #(.NUM_CH(4), .STAGGER(3), .RST_CYCLES(2)) u_c (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .halt_in(halt_in),
        .ch_rst(c_ch), .run(c_run), .cycle_count(c_cnt), .done(c_done),
        .timeout(c_tmo), .state_o(c_st));

    run_reset_sequencer #(.CNT_W(5), .TIMEOUT(0)) u_d (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .halt_in(halt_in),
        .ch_rst(d_ch), .run(d_run), .cycle_count(d_cnt), .done(d_done),
        .timeout(d_tmo), .state_o(d_st));

    // Model: state code, edges since start, cycle count.
    typedef struct { int st; int t; longint cnt; } mst_t;
    typedef struct { int rc; int nch; int stg; int tmo; int cw; } cfg_t;

    mst_t  m   [4];
    cfg_t  cfg [4];
    string nms [4];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic mst_t mstep(mst_t s, cfg_t c, bit r, bit st, bit ab, bit h);
        mst_t   n;
        longint maxv;
        n    = s;
        maxv = (longint'(1) << c.cw) - 1;
        if (r) begin
            n.st = 0; n.t = 0; n.cnt = 0;
            return n;
        end
        case (s.st)
            0: if (st) begin n.st = 1; n.t = 0; end
            1: if (ab) begin n.st = 0; n.cnt = 0; end
               else begin
                   n.t = s.t + 1;
                   if (n.t == c.rc + (c.nch - 1) * c.stg) n.st = 2;
               end
            2: if (ab) begin n.st = 0; n.cnt = 0; end
               else if (h) n.st = 3;
               else begin
                   if (s.cnt < maxv) n.cnt = s.cnt + 1;
                   if (c.tmo != 0 && n.cnt == c.tmo) n.st = 4;
               end
            default: if (st) begin n.st = 1; n.t = 0; n.cnt = 0; end
        endcase
        return n;
    endfunction

    function automatic logic [63:0] exp_ch(mst_t s, cfg_t c);
        logic [63:0] v = '0;
        for (int i = 0; i < c.nch; i++) begin
            if (s.st == 0 || s.st == 4) v[i] = 1'b1;
            else if (s.st == 1)         v[i] = (s.t < c.rc + i * c.stg);
        end
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_model(int k, logic [63:0] ch, logic run, logic [63:0] cnt,
                             logic dn, logic tm, logic [2:0] st);
        chk($sformatf("%s.state", nms[k]), 64'(st), 64'(m[k].st));
        chk($sformatf("%s.ch_rst", nms[k]), ch, exp_ch(m[k], cfg[k]));
        chk($sformatf("%s.run", nms[k]), 64'(run), 64'(m[k].st == 2));
        chk($sformatf("%s.count", nms[k]), cnt, 64'(m[k].cnt));
        chk($sformatf("%s.done", nms[k]), 64'(dn), 64'(m[k].st == 3));
        chk($sformatf("%s.timeout", nms[k]), 64'(tm), 64'(m[k].st == 4));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) m[k] = mstep(m[k], cfg[k], rst, start, abort, halt_in);
        chk_model(0, 64'(a_ch), a_run, 64'(a_cnt), a_done, a_tmo, a_st);
        chk_model(1, 64'(b_ch), b_run, 64'(b_cnt), b_done, b_tmo, b_st);
        chk_model(2, 64'(c_ch), c_run, 64'(c_cnt), c_done, c_tmo, c_st);
        chk_model(3, 64'(d_ch), d_run, 64'(d_cnt), d_done, d_tmo, d_st);
    endtask

    task automatic set_in(bit r, bit s, bit a, bit h);
        rst = r; start = s; abort = a; halt_in = h;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset, then start; returns after the edge where A/B/D enter RUN.
    task automatic reset_and_start();
        set_in(1, 0, 0, 0); tick();
        set_in(0, 1, 0, 0); tick();
        set_in(0, 0, 0, 0); ticks(3);
    endtask

    typedef struct {
        logic r, s, a, h;
        logic [2:0]  st;
        logic [1:0]  ch;
        logic        run;
        logic [31:0] cnt;
        logic        dn, tm;
    } vec_t;

    vec_t tbl [16];

    initial begin
        cfg[0] = '{2, 2, 1, 100000, 32}; nms[0] = "A";
        cfg[1] = '{2, 2, 1, 20, 32};     nms[1] = "B";
        cfg[2] = '{2, 4, 3, 100000, 32}; nms[2] = "C";
        cfg[3] = '{2, 2, 1, 0, 5};       nms[3] = "D";
        for (int k = 0; k < 4; k++) m[k] = '{0, 0, 0};

        tbl[0]  = '{1,0,0,0, 3'd0, 2'b11, 0, 0, 0, 0};
        tbl[1]  = '{0,0,0,0, 3'd0, 2'b11, 0, 0, 0, 0};
        tbl[2]  = '{0,1,0,0, 3'd1, 2'b11, 0, 0, 0, 0};
        tbl[3]  = '{0,0,0,1, 3'd1, 2'b11, 0, 0, 0, 0};
        tbl[4]  = '{0,1,0,0, 3'd1, 2'b10, 0, 0, 0, 0};
        tbl[5]  = '{0,0,0,0, 3'd2, 2'b00, 1, 0, 0, 0};
        tbl[6]  = '{0,0,0,0, 3'd2, 2'b00, 1, 1, 0, 0};
        tbl[7]  = '{0,1,0,0, 3'd2, 2'b00, 1, 2, 0, 0};
        tbl[8]  = '{0,0,0,1, 3'd3, 2'b00, 0, 2, 1, 0};
        tbl[9]  = '{0,0,0,0, 3'd3, 2'b00, 0, 2, 1, 0};
        tbl[10] = '{0,0,1,0, 3'd3, 2'b00, 0, 2, 1, 0};
        tbl[11] = '{0,1,0,0, 3'd1, 2'b11, 0, 0, 0, 0};
        tbl[12] = '{0,1,1,0, 3'd0, 2'b11, 0, 0, 0, 0};
        tbl[13] = '{0,1,0,0, 3'd1, 2'b11, 0, 0, 0, 0};
        tbl[14] = '{0,0,0,0, 3'd1, 2'b11, 0, 0, 0, 0};
        tbl[15] = '{0,0,1,0, 3'd0, 2'b11, 0, 0, 0, 0};

        for (int v = 0; v < 16; v++) begin
            set_in(tbl[v].r, tbl[v].s, tbl[v].a, tbl[v].h);
            tick();
            chk($sformatf("vec%0d.state", v), 64'(a_st), 64'(tbl[v].st));
            chk($sformatf("vec%0d.ch_rst", v), 64'(a_ch), 64'(tbl[v].ch));
            chk($sformatf("vec%0d.run", v), 64'(a_run), 64'(tbl[v].run));
            chk($sformatf("vec%0d.count", v), 64'(a_cnt), 64'(tbl[v].cnt));
            chk($sformatf("vec%0d.done", v), 64'(a_done), 64'(tbl[v].dn));
            chk($sformatf("vec%0d.timeout", v), 64'(a_tmo), 64'(tbl[v].tm));
        end

        // Four-channel stagger: releases at E0+2, +5, +8, +11.
        set_in(1, 0, 0, 0); tick();
        set_in(0, 1, 0, 0); tick();
        set_in(0, 0, 0, 0);
        for (int k = 1; k <= 11; k++) begin
            logic [3:0] e;
            tick();
            e = (k < 2) ? 4'hF : (k < 5) ? 4'hE : (k < 8) ? 4'hC : (k < 11) ? 4'h8 : 4'h0;
            chk($sformatf("stagger.k%0d.ch_rst", k), 64'(c_ch), 64'(e));
            chk($sformatf("stagger.k%0d.run", k), 64'(c_run), 64'(k == 11));
        end
        chk("stagger.state", 64'(c_st), 64'd2);

        // Watchdog expiry at 20.
        reset_and_start();
        ticks(20);
        chk("wd.b_state", 64'(b_st), 64'd4);
        chk("wd.b_timeout", 64'(b_tmo), 64'd1);
        chk("wd.b_run", 64'(b_run), 64'd0);
        chk("wd.b_ch_rst", 64'(b_ch), 64'd3);
        chk("wd.b_count", 64'(b_cnt), 64'd20);
        chk("wd.a_count", 64'(a_cnt), 64'd20);
        ticks(3);
        chk("wd.b_frozen", 64'(b_cnt), 64'd20);

        // Halt on the last cycle before expiry wins.
        reset_and_start();
        ticks(19);
        set_in(0, 0, 0, 1); tick();
        chk("halt19.b_done", 64'(b_done), 64'd1);
        chk("halt19.b_timeout", 64'(b_tmo), 64'd0);
        chk("halt19.b_count", 64'(b_cnt), 64'd19);

        // Ten run cycles then halt, frozen, then restart clears done.
        reset_and_start();
        ticks(10);
        set_in(0, 0, 0, 1); tick();
        chk("halt10.state", 64'(a_st), 64'd3);
        chk("halt10.count", 64'(a_cnt), 64'd10);
        chk("halt10.run", 64'(a_run), 64'd0);
        set_in(0, 0, 0, 0); ticks(5);
        chk("halt10.frozen", 64'(a_cnt), 64'd10);
        set_in(0, 1, 0, 0); tick();
        chk("restart.state", 64'(a_st), 64'd1);
        chk("restart.done", 64'(a_done), 64'd0);
        chk("restart.count", 64'(a_cnt), 64'd0);

        // rst and abort mid-RUN at count 7.
        reset_and_start();
        ticks(7);
        chk("mid.count7", 64'(a_cnt), 64'd7);
        set_in(1, 0, 0, 0); tick();
        chk("rstmid.state", 64'(a_st), 64'd0);
        chk("rstmid.ch_rst", 64'(a_ch), 64'd3);
        chk("rstmid.count", 64'(a_cnt), 64'd0);
        set_in(0, 1, 0, 0); tick();
        set_in(0, 0, 0, 0); ticks(3 + 7);
        set_in(0, 0, 1, 0); tick();
        chk("abortmid.state", 64'(a_st), 64'd0);
        chk("abortmid.ch_rst", 64'(a_ch), 64'd3);
        chk("abortmid.count", 64'(a_cnt), 64'd0);

        // Saturation of a 5-bit counter with the watchdog disabled.
        reset_and_start();
        ticks(40);
        chk("sat.d_count", 64'(d_cnt), 64'd31);
        chk("sat.d_state", 64'(d_st), 64'd2);

        // Randomized traffic, alternating frequent and rare halts.
        for (int i = 0; i < 4000; i++) begin
            int hp;
            hp = ((i / 500) % 2 == 0) ? 8 : 80;
            set_in($urandom_range(0, 149) == 0, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 49) == 0, $urandom_range(0, hp) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
